// File: rtl/ram_loader.sv
// Boot-time loader: assembles little-endian 16-bit words from a byte stream and writes them to consecutive RAM addresses.
// Optional LOADER_CHECKSUM_EN adds a trailing 16-bit XOR checksum frame field and drives error.
module ram_loader #(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        initializing,
  output logic [15:0] init_addr,
  output logic [15:0] init_data,
  output logic        init_we,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DAT_LO,
    S_DAT_HI,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CK_LO,
    S_CK_HI,
`endif
    S_DONE
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CK_LO;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [3:0] WC_LAST = 4'(WRITE_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  lo_byte;
  logic [15:0] count;
  logic [3:0]  wcnt;
  logic        accept;
  logic        start_ok;
  logic        wr_last;

  assign accept   = byte_valid & byte_ready;
  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));
  assign wr_last  = (state == S_WRITE) && (wcnt == WC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    init_we    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = ({byte_in, lo_byte} == 16'd0) ? S_END : S_DAT_LO;
      end
      S_DAT_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_DAT_HI;
      end
      S_DAT_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        init_we = 1'b1;
        if (wcnt == WC_LAST) state_next = (count == 16'd1) ? S_END : S_DAT_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CK_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_CK_HI;
      end
      S_CK_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_DONE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic        error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      initializing <= 1'b0;
      done         <= 1'b0;
      init_addr    <= 16'd0;
      init_data    <= 16'd0;
      lo_byte      <= 8'd0;
      count        <= 16'd0;
      wcnt         <= 4'd0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 16'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        initializing <= 1'b1;
        done         <= 1'b0;
        init_addr    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        csum         <= 16'd0;
        error_q      <= 1'b0;
`endif
      end
      if ((state_next == S_DONE) && (state != S_DONE)) begin
        initializing <= 1'b0;
        done         <= 1'b1;
      end
      // low bytes are parked in lo_byte so init_data only changes when a full word lands
      if (accept) begin
        case (state)
          S_LEN_HI: count <= {byte_in, lo_byte};
          S_DAT_HI: begin
            init_data <= {byte_in, lo_byte};
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ {byte_in, lo_byte};
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CK_HI:  error_q <= ({byte_in, lo_byte} != csum);
`endif
          default:  lo_byte <= byte_in;
        endcase
      end
      if (state == S_WRITE) wcnt <= wr_last ? 4'd0 : wcnt + 4'd1;
      else                  wcnt <= 4'd0;
      if (wr_last) begin
        init_addr <= init_addr + 16'd1;
        count     <= count - 16'd1;
      end
    end
  end

endmodule
